// File: rtl/vreduction_wb_buffer_if.sv
// Handshake bundle between the reduction unit, the writeback buffer and the VRF writeback port.
// The master side drives issue, result and writeback-ready. The slave side is the buffer.
interface vreduction_wb_buffer_if #(
   parameter int unsigned TAG_W  = 5,
   parameter int unsigned DATA_W = 512
);
   logic              issue_valid;
   logic [TAG_W-1:0]  issue_tag;
   logic              issue_ok;
   logic              red_valid;
   logic [DATA_W-1:0] red_vector;
   logic              wb_valid;
   logic              wb_ready;
   logic [TAG_W-1:0]  wb_tag;
   logic [DATA_W-1:0] wb_data;

   modport master (
      output issue_valid, issue_tag, red_valid, red_vector, wb_ready,
      input  issue_ok, wb_valid, wb_tag, wb_data
   );

   modport slave (
      input  issue_valid, issue_tag, red_valid, red_vector, wb_ready,
      output issue_ok, wb_valid, wb_tag, wb_data
   );
endinterface

// File: rtl/vreduction_wb_buffer.sv
// Writeback buffer for the vector reduction unit.
// Results from the reduction unit are paired with the destination tag recorded at issue time.
// They are then queued and drained to the VRF writeback port in issue order. Upstream credit
// (issue_ok) guarantees that the non-stallable reduction unit never overruns the buffer.
// Optional feature: define VRED_WB_BYPASS_EN to forward a result combinationally to the
// writeback port when the queue is empty.
module vreduction_wb_buffer #(
   parameter int unsigned NUM_ELEMENTS = 32,
   parameter int unsigned DEPTH        = 4,
   parameter int unsigned TAG_W        = 5,
   localparam int unsigned DATA_W      = NUM_ELEMENTS * 16,
   localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
   input  logic                 CLK,
   input  logic                 RST,
   vreduction_wb_buffer_if.slave bus,
   output logic [CNT_W-1:0]     occupancy,
   output logic [CNT_W-1:0]     inflight,
   output logic                 err_overflow,
   output logic                 err_orphan
);

   localparam int unsigned PTR_W = $clog2(DEPTH);

   // Tag FIFO: destination tags of ops issued but not yet returned
   logic [TAG_W-1:0]  tag_mem [DEPTH];
   logic [PTR_W-1:0]  tag_wr_ptr_q, tag_wr_ptr_d, tag_rd_ptr_q, tag_rd_ptr_d;
   // Data FIFO: completed {tag, vector} entries awaiting writeback
   logic [TAG_W-1:0]  dtag_mem [DEPTH];
   logic [DATA_W-1:0] data_mem [DEPTH];
   logic [PTR_W-1:0]  data_wr_ptr_q, data_wr_ptr_d, data_rd_ptr_q, data_rd_ptr_d;

   logic [CNT_W-1:0]  occupancy_q, occupancy_d, inflight_q, inflight_d;
   logic              err_overflow_q, err_overflow_d, err_orphan_q, err_orphan_d;

   logic [CNT_W:0]    credit_sum;
   logic              issue_acc, issue_drop, red_match, red_orphan;
   logic              fifo_full, fifo_nonempty, store_pop;
   logic              bypass_hit, bypass_take, push_req, push_drop, data_push;
   logic [TAG_W-1:0]  head_tag;

   // Credit is derived from registered counts only, so a same-cycle pop frees credit next cycle
   assign credit_sum    = {1'b0, occupancy_q} + {1'b0, inflight_q};
   assign bus.issue_ok  = credit_sum < (CNT_W + 1)'(DEPTH);
   assign issue_acc     = bus.issue_valid & bus.issue_ok;
   assign issue_drop    = bus.issue_valid & ~bus.issue_ok;
   assign red_match     = bus.red_valid & (inflight_q != '0);
   assign red_orphan    = bus.red_valid & (inflight_q == '0);
   assign head_tag      = tag_mem[tag_rd_ptr_q];
   assign fifo_full     = occupancy_q == CNT_W'(DEPTH);
   assign fifo_nonempty = occupancy_q != '0;
   assign store_pop     = fifo_nonempty & bus.wb_ready;

`ifdef VRED_WB_BYPASS_EN
   assign bypass_hit  = ~fifo_nonempty & red_match;
   assign bypass_take = bypass_hit & bus.wb_ready;
`else
   assign bypass_hit  = 1'b0;
   assign bypass_take = 1'b0;
`endif

   // A bypassed result accepted immediately is never stored
   assign push_req  = red_match & ~bypass_take;
   // Unreachable while credits are honoured; kept as a safety net
   assign push_drop = push_req & fifo_full & ~store_pop;
   assign data_push = push_req & ~push_drop;

   // Writeback port: stored head entry, else bypassed result, else zero
   always_comb begin
      bus.wb_valid = fifo_nonempty | bypass_hit;
      bus.wb_tag   = '0;
      bus.wb_data  = '0;
      if (fifo_nonempty) begin
         bus.wb_tag  = dtag_mem[data_rd_ptr_q];
         bus.wb_data = data_mem[data_rd_ptr_q];
      end else if (bypass_hit) begin
         bus.wb_tag  = head_tag;
         bus.wb_data = bus.red_vector;
      end
   end

   // Next-state for pointers, counters and sticky errors
   always_comb begin
      tag_wr_ptr_d   = tag_wr_ptr_q;
      tag_rd_ptr_d   = tag_rd_ptr_q;
      data_wr_ptr_d  = data_wr_ptr_q;
      data_rd_ptr_d  = data_rd_ptr_q;
      inflight_d     = inflight_q;
      occupancy_d    = occupancy_q;
      err_overflow_d = err_overflow_q | issue_drop | push_drop;
      err_orphan_d   = err_orphan_q | red_orphan;

      if (issue_acc) tag_wr_ptr_d = tag_wr_ptr_q + PTR_W'(1);
      if (red_match) tag_rd_ptr_d = tag_rd_ptr_q + PTR_W'(1);
      if (data_push) data_wr_ptr_d = data_wr_ptr_q + PTR_W'(1);
      if (store_pop) data_rd_ptr_d = data_rd_ptr_q + PTR_W'(1);

      case ({issue_acc, red_match})
         2'b10:   inflight_d = inflight_q + CNT_W'(1);
         2'b01:   inflight_d = inflight_q - CNT_W'(1);
         default: inflight_d = inflight_q;
      endcase

      case ({data_push, store_pop})
         2'b10:   occupancy_d = occupancy_q + CNT_W'(1);
         2'b01:   occupancy_d = occupancy_q - CNT_W'(1);
         default: occupancy_d = occupancy_q;
      endcase
   end

   // Control state register with asynchronous reset
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         tag_wr_ptr_q   <= '0;
         tag_rd_ptr_q   <= '0;
         data_wr_ptr_q  <= '0;
         data_rd_ptr_q  <= '0;
         inflight_q     <= '0;
         occupancy_q    <= '0;
         err_overflow_q <= 1'b0;
         err_orphan_q   <= 1'b0;
      end else begin
         tag_wr_ptr_q   <= tag_wr_ptr_d;
         tag_rd_ptr_q   <= tag_rd_ptr_d;
         data_wr_ptr_q  <= data_wr_ptr_d;
         data_rd_ptr_q  <= data_rd_ptr_d;
         inflight_q     <= inflight_d;
         occupancy_q    <= occupancy_d;
         err_overflow_q <= err_overflow_d;
         err_orphan_q   <= err_orphan_d;
      end
   end

   // Storage arrays, not reset; the outputs are gated by occupancy instead
   always_ff @(posedge CLK) begin
      if (issue_acc) tag_mem[tag_wr_ptr_q] <= bus.issue_tag;
      if (data_push) begin
         dtag_mem[data_wr_ptr_q] <= head_tag;
         data_mem[data_wr_ptr_q] <= bus.red_vector;
      end
   end

   assign occupancy    = occupancy_q;
   assign inflight     = inflight_q;
   assign err_overflow = err_overflow_q;
   assign err_orphan   = err_orphan_q;

endmodule

// File: tb/tb_vreduction_wb_buffer.sv
// Directed self-checking bench for vreduction_wb_buffer (DEPTH=4, TAG_W=5, 32 x fp16).
module tb_vreduction_wb_buffer;

   logic       CLK;
   logic       RST;
   logic [2:0] occupancy;
   logic [2:0] inflight;
   logic       err_overflow;
   logic       err_orphan;
   int         pass_cnt = 0;
   int         total_cnt = 0;

   vreduction_wb_buffer_if #(.TAG_W(5), .DATA_W(512)) bus ();

   vreduction_wb_buffer #(.NUM_ELEMENTS(32), .DEPTH(4), .TAG_W(5)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .bus          (bus),
      .occupancy    (occupancy),
      .inflight     (inflight),
      .err_overflow (err_overflow),
      .err_orphan   (err_orphan)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [511:0] fill(input logic [15:0] v);
      fill = {32{v}};
   endfunction

   // Advance past the next rising edge; inputs set after this are sampled at the following edge
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      bus.issue_valid = 1'b0; bus.issue_tag = '0; bus.red_valid = 1'b0;
      bus.red_vector = '0; bus.wb_ready = 1'b0;
      tick(); tick();
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL rst_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (inflight !== 3'd0) $display("FAIL rst_inflight: got %0d want 0", inflight); else pass_cnt++;
      total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL rst_wb_valid: got %b want 0", bus.wb_valid); else pass_cnt++;
      total_cnt++; if (bus.issue_ok !== 1'b1) $display("FAIL rst_issue_ok: got %b want 1", bus.issue_ok); else pass_cnt++;
      total_cnt++; if (bus.wb_tag !== 5'd0 || bus.wb_data !== 512'd0) $display("FAIL rst_wb_out: got tag %0h data %0h want 0", bus.wb_tag, bus.wb_data); else pass_cnt++;
      total_cnt++; if ({err_overflow, err_orphan} !== 2'b00) $display("FAIL rst_errs: got %b want 00", {err_overflow, err_orphan}); else pass_cnt++;
      RST = 1'b0;
      bus.issue_valid = 1'b1; bus.issue_tag = 5'd10; tick();
      bus.issue_tag = 5'd11; tick();
      bus.issue_valid = 1'b0; bus.red_valid = 1'b1; bus.red_vector = fill(16'hABCD); tick();
      bus.red_valid = 1'b0;
      total_cnt++; if ({occupancy, inflight, bus.wb_valid} !== {3'd1, 3'd1, 1'b1}) $display("FAIL mid_stream: got occ %0d infl %0d wbv %b want 1 1 1", occupancy, inflight, bus.wb_valid); else pass_cnt++;
      // Asynchronous reset checked well before the next clock edge
      #2 RST = 1'b1;
      #1;
      total_cnt++; if (occupancy !== 3'd0) $display("FAIL async_rst_occ: got %0d want 0", occupancy); else pass_cnt++;
      total_cnt++; if (inflight !== 3'd0) $display("FAIL async_rst_inflight: got %0d want 0", inflight); else pass_cnt++;
      total_cnt++; if ({bus.wb_valid, bus.issue_ok} !== 2'b01) $display("FAIL async_rst_flags: got wbv/ok %b want 01", {bus.wb_valid, bus.issue_ok}); else pass_cnt++;
      tick();
      RST = 1'b0;
   endtask

   task automatic test_single_op();
      bus.issue_valid = 1'b1; bus.issue_tag = 5'd7; tick();
      bus.issue_valid = 1'b0; tick(); tick();
      total_cnt++; if (inflight !== 3'd1) $display("FAIL single_inflight: got %0d want 1", inflight); else pass_cnt++;
      bus.red_valid = 1'b1; bus.red_vector = fill(16'h3C00); bus.wb_ready = 1'b1;
      #1;
`ifdef VRED_WB_BYPASS_EN
      total_cnt++; if ({bus.wb_valid, bus.wb_tag} !== {1'b1, 5'd7} || bus.wb_data !== fill(16'h3C00)) $display("FAIL single_bypass: got wbv %b tag %0d data %0h want 1 7 3c00s", bus.wb_valid, bus.wb_tag, bus.wb_data); else pass_cnt++;
      tick();
      bus.red_valid = 1'b0;
`else
      total_cnt++; if (bus.wb_valid !== 1'b0) $display("FAIL single_early: got wbv %b want 0", bus.wb_valid); else pass_cnt++;
      tick();
      bus.red_valid = 1'b0;
      total_cnt++; if ({bus.wb_valid, bus.wb_tag} !== {1'b1, 5'd7} || bus.wb_data !== fill(16'h3C00)) $display("FAIL single_wb: got wbv %b tag %0d data %0h want 1 7 3c00s", bus.wb_valid, bus.wb_tag, bus.wb_data); else pass_cnt++;
      tick();
`endif
      total_cnt++; if ({bus.wb_valid, occupancy, inflight} !== {1'b0, 3'd0, 3'd0}) $display("FAIL single_drained: got wbv %b occ %0d infl %0d want 0 0 0", bus.wb_valid, occupancy, inflight); else pass_cnt++;
      bus.wb_ready = 1'b0;
   endtask

   task automatic test_credit_fill();
      bus.wb_ready = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         bus.issue_valid = 1'b1; bus.issue_tag = 5'(k); tick();
         total_cnt++; if (bus.issue_ok !== (k < 4)) $display("FAIL credit_ok_%0d: got %b want %b", k, bus.issue_ok, (k < 4)); else pass_cnt++;
      end
      bus.issue_tag = 5'd9; tick();
      bus.issue_valid = 1'b0;
      total_cnt++; if (err_overflow !== 1'b1) $display("FAIL overflow_flag: got %b want 1", err_overflow); else pass_cnt++;
      total_cnt++; if ({inflight, bus.issue_ok} !== {3'd4, 1'b0}) $display("FAIL overflow_counts: got infl %0d ok %b want 4 0", inflight, bus.issue_ok); else pass_cnt++;
   endtask

   task automatic test_backpressure();
      logic       ready_seq [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
      logic [4:0] tag_seq   [5] = '{5'd2, 5'd2, 5'd3, 5'd4, 5'd0};
      logic [2:0] occ_seq   [5] = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
      logic [511:0] exp_data;
      for (int k = 1; k <= 4; k++) begin
         bus.red_valid = 1'b1; bus.red_vector = fill(16'h0100 + 16'(k)); tick();
      end
      bus.red_valid = 1'b0;
      total_cnt++; if ({occupancy, inflight, bus.issue_ok} !== {3'd4, 3'd0, 1'b0}) $display("FAIL bp_full: got occ %0d infl %0d ok %b want 4 0 0", occupancy, inflight, bus.issue_ok); else pass_cnt++;
      total_cnt++; if (bus.wb_tag !== 5'd1 || bus.wb_data !== fill(16'h0101)) $display("FAIL bp_head: got tag %0d data %0h want 1 0101s", bus.wb_tag, bus.wb_data); else pass_cnt++;
      for (int i = 0; i < 5; i++) begin
         bus.wb_ready = ready_seq[i]; tick();
         exp_data = (tag_seq[i] == 5'd0) ? 512'd0 : fill(16'h0100 + 16'(tag_seq[i]));
         total_cnt++; if (bus.wb_tag !== tag_seq[i] || bus.wb_data !== exp_data) $display("FAIL bp_order_%0d: got tag %0d data %0h want tag %0d data %0h", i, bus.wb_tag, bus.wb_data, tag_seq[i], exp_data); else pass_cnt++;
         total_cnt++; if (occupancy !== occ_seq[i]) $display("FAIL bp_occ_%0d: got %0d want %0d", i, occupancy, occ_seq[i]); else pass_cnt++;
         if (i == 0) begin
            total_cnt++; if (bus.issue_ok !== 1'b1) $display("FAIL bp_credit_return: got %b want 1", bus.issue_ok); else pass_cnt++;
         end
      end
      bus.wb_ready = 1'b0;
   endtask

   task automatic test_simultaneous();
      for (int k = 20; k <= 22; k++) begin
         bus.issue_valid = 1'b1; bus.issue_tag = 5'(k); tick();
      end
      bus.issue_valid = 1'b0;
      bus.red_valid = 1'b1; bus.red_vector = fill(16'hAAAA); tick();
      bus.red_vector = fill(16'hBBBB); tick();
      bus.red_valid = 1'b0;
      total_cnt++; if ({occupancy, inflight, bus.wb_tag} !== {3'd2, 3'd1, 5'd20}) $display("FAIL sim_setup: got occ %0d infl %0d tag %0d want 2 1 20", occupancy, inflight, bus.wb_tag); else pass_cnt++;
      bus.issue_valid = 1'b1; bus.issue_tag = 5'd23;
      bus.red_valid = 1'b1; bus.red_vector = fill(16'hCCCC); bus.wb_ready = 1'b1;
      tick();
      bus.issue_valid = 1'b0; bus.red_valid = 1'b0;
      total_cnt++; if ({occupancy, inflight} !== {3'd2, 3'd1}) $display("FAIL sim_counts: got occ %0d infl %0d want 2 1", occupancy, inflight); else pass_cnt++;
      total_cnt++; if (bus.wb_tag !== 5'd21 || bus.wb_data !== fill(16'hBBBB)) $display("FAIL sim_head: got tag %0d data %0h want 21 bbbbs", bus.wb_tag, bus.wb_data); else pass_cnt++;
      tick();
      total_cnt++; if (bus.wb_tag !== 5'd22 || bus.wb_data !== fill(16'hCCCC)) $display("FAIL sim_pair: got tag %0d data %0h want 22 ccccs", bus.wb_tag, bus.wb_data); else pass_cnt++;
      tick();
      bus.red_valid = 1'b1; bus.red_vector = fill(16'hDDDD); tick();
      bus.red_valid = 1'b0;
      total_cnt++; if (bus.wb_tag !== 5'd23 || bus.wb_data !== fill(16'hDDDD) || inflight !== 3'd0) $display("FAIL sim_late: got tag %0d infl %0d data %0h want 23 0 dddds", bus.wb_tag, inflight, bus.wb_data); else pass_cnt++;
      tick();
      total_cnt++; if ({occupancy, bus.wb_valid} !== {3'd0, 1'b0}) $display("FAIL sim_drain: got occ %0d wbv %b want 0 0", occupancy, bus.wb_valid); else pass_cnt++;
      bus.wb_ready = 1'b0;
   endtask

   task automatic test_orphan();
      total_cnt++; if (err_orphan !== 1'b0) $display("FAIL orphan_pre: got %b want 0", err_orphan); else pass_cnt++;
      bus.red_valid = 1'b1; bus.red_vector = fill(16'h1234); tick();
      bus.red_valid = 1'b0;
      total_cnt++; if (err_orphan !== 1'b1) $display("FAIL orphan_flag: got %b want 1", err_orphan); else pass_cnt++;
      total_cnt++; if ({occupancy, bus.wb_valid} !== {3'd0, 1'b0}) $display("FAIL orphan_dropped: got occ %0d wbv %b want 0 0", occupancy, bus.wb_valid); else pass_cnt++;
      tick();
      total_cnt++; if ({err_overflow, err_orphan} !== 2'b11) $display("FAIL errs_sticky: got %b want 11", {err_overflow, err_orphan}); else pass_cnt++;
   endtask

   initial begin
      test_reset();
      test_single_op();
      test_credit_fill();
      test_backpressure();
      test_simultaneous();
      test_orphan();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
